sample_deserializer: RTL and testbench
======================================

SAMPLE_DESERIALIZER -- requirements
Module: sample_deserializer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning: 1 = first serial bit is D[11]; 0 = first serial bit is D[0].
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sdata  input  1  serial sample bit, sampled on rising clk.
REQ-005 SHALL have port sframe  input  1  frame enable; high for the 12 bit-cycles of one sample.
REQ-006 SHALL have port d_out  output  12  assembled two's-complement sample; feeds converter input D.
REQ-007 SHALL have port d_valid  output  1  d_out holds an unconsumed sample.
REQ-008 SHALL have port d_ready  input  1  consumer accepts d_out this cycle.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: completed sample dropped.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: frame ended short.
REQ-011 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-012 SHALL use three states: IDLE, SHIFT, WAIT_LOW.
REQ-013 IDLE with sframe=1 SHALL capture sdata as bit 1 in that cycle, set bit count to 1, and enter SHIFT.
REQ-014 SHIFT with sframe=1 SHALL capture one bit per cycle into a 12-bit shift register; no gaps allowed.
REQ-015 SHIFT SHALL complete a word on the cycle the 12th bit is captured, then enter WAIT_LOW, or IDLE if sframe=0 on the next cycle.
REQ-016 SHIFT with sframe=0 before 12 bits SHALL discard the partial word, pulse frame_err the next cycle, and return to IDLE.
REQ-017 WAIT_LOW SHALL ignore sdata and return to IDLE on the first cycle sframe=0; bits beyond 12 are never captured.
REQ-018 Completed word SHALL be available on d_out with d_valid=1 in the cycle after the 12th bit is captured (latency 1 from last bit).
REQ-019 Output register SHALL be separate from the shift register, so a new frame may shift while d_out is held.
REQ-020 Transfer SHALL occur on any cycle with d_valid=1 and d_ready=1; d_valid SHALL drop the next cycle unless a new word loads.
REQ-021 d_out SHALL hold stable while d_valid=1 and d_ready=0.
REQ-022 Word completing while d_valid=1 and d_ready=0 SHALL be dropped; d_out keeps the old word; overrun pulses for 1 cycle.
REQ-023 Word completing in the same cycle as a transfer SHALL load; d_valid stays 1; no overrun.
REQ-024 d_ready while d_valid=0 SHALL have no effect.
REQ-025 MSB_FIRST=1 SHALL map bit k (1..12) to d_out[12-k]; MSB_FIRST=0 SHALL map bit k to d_out[k-1].

Reset
REQ-026 rst_n=0 SHALL immediately force state to IDLE, bit count to 0, shift register to 0, d_out=12'h000, d_valid=0, overrun=0, frame_err=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial word without a frame_err pulse.
REQ-028 After rst_n rises, a frame SHALL be recognised only on a cycle with sframe=1 while in IDLE; a frame already in progress SHALL be captured from its current bit as bit 1.

Configuration
REQ-029 Macro SAMPLE_SAT_EN, when defined, SHALL replace a completed word 12'h800 with 12'h801 before loading d_out; all other words SHALL pass unchanged.
REQ-030 Without SAMPLE_SAT_EN, 12'h800 SHALL pass to d_out unchanged; no saturation logic is present.

Verification
REQ-031 Reset, MSB_FIRST=1, sframe high 12 cycles with bits 1111_1111_0110, d_ready=1 -> d_out=12'hFF6 with d_valid=1 for exactly 1 cycle, one cycle after the last bit.
REQ-032 Frame 12'h123, d_ready=0; second frame 12'h456 completes -> d_out stays 12'h123; overrun pulses once; d_ready=1 -> 12'h123 transfers.
REQ-033 sframe drops after 7 bits -> frame_err pulses 1 cycle, d_valid stays 0, next full frame 12'h07F -> d_out=12'h07F.
REQ-034 sframe high 15 cycles -> only first 12 bits used, busy high until the cycle after sframe falls, then IDLE.
REQ-035 Frame 12'h800: with SAMPLE_SAT_EN -> d_out=12'h801; without it -> d_out=12'h800.
REQ-036 rst_n pulsed low after 5 bits, with d_valid=1 holding 12'hABC -> all outputs 0 immediately, no frame_err, and the next full frame assembles correctly.

Source files
------------

// File: rtl/sample_deserializer.sv
// sample_deserializer: assembles 12-bit two's-complement samples from a framed serial stream.
// Ports: clk, rst_n (async, active low); sdata/sframe serial input and frame enable;
// d_out/d_valid/d_ready output handshake; overrun and frame_err one-cycle pulses; busy = not IDLE.
// Optional SAMPLE_SAT_EN: a completed 12'h800 is loaded as 12'h801.
module sample_deserializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdata,
  input  logic        sframe,
  output logic [11:0] d_out,
  output logic        d_valid,
  input  logic        d_ready,
  output logic        overrun,
  output logic        frame_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_LOW} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] sr_q, sr_d, base, word, dout_q, dout_d;
  logic        valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic        cap, done, load;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ferr_d  = 1'b0;
    cap     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (sframe) begin
        cap     = 1'b1;
        cnt_d   = 4'd1;
        state_d = SHIFT;
      end
      SHIFT: if (sframe) begin
        cap     = 1'b1;
        cnt_d   = cnt_q + 4'd1;
        done    = cnt_q == 4'd11;
        state_d = done ? WAIT_LOW : SHIFT;
      end else begin
        ferr_d  = 1'b1;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      WAIT_LOW: if (!sframe) begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a new frame always starts from an empty register so stale bits never leak in
    base = state_q == IDLE ? 12'h000 : sr_q;
    sr_d = ferr_d ? 12'h000 : cap ? (MSB_FIRST ? {base[10:0], sdata} : {sdata, base[11:1]}) : sr_q;
  end
  always_comb begin
`ifdef SAMPLE_SAT_EN
    word = sr_d == 12'h800 ? 12'h801 : sr_d;
`else
    word = sr_d;
`endif
    // a finished word loads if the output slot is empty or being drained this cycle
    load    = done && (!valid_q || d_ready);
    dout_d  = load ? word : dout_q;
    valid_d = load | (valid_q & ~d_ready);
    ovr_d   = done & valid_q & ~d_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sr_q    <= 12'h000;
      dout_q  <= 12'h000;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end
  assign d_out     = dout_q;
  assign d_valid   = valid_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_sample_deserializer.sv
// tb_sample_deserializer: directed table-driven checks of sample_deserializer in both bit orders.
module tb_sample_deserializer;
  logic clk = 1'b0, rst_n = 1'b0, sdata = 1'b0, sframe = 1'b0, d_ready = 1'b0;
  logic [11:0] d_out, d_out_l;
  logic d_valid, overrun, frame_err, busy;
  logic d_valid_l, overrun_l, frame_err_l, busy_l;
  int total = 0, bad = 0;
  typedef struct packed {logic [11:0] w, em, el;} vec_t;
  vec_t tv[7];
`ifdef SAMPLE_SAT_EN
  localparam logic [11:0] SAT = 12'h801;
`else
  localparam logic [11:0] SAT = 12'h800;
`endif
  sample_deserializer #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sdata(sdata), .sframe(sframe), .d_out(d_out),
    .d_valid(d_valid), .d_ready(d_ready), .overrun(overrun), .frame_err(frame_err), .busy(busy));
  sample_deserializer #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sdata(sdata), .sframe(sframe), .d_out(d_out_l),
    .d_valid(d_valid_l), .d_ready(d_ready), .overrun(overrun_l), .frame_err(frame_err_l), .busy(busy_l));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic b, input logic f);
    sdata  = b;
    sframe = f;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [11:0] w, input int n);
    for (int i = 11; i > 11 - n; i--) step(w[i], 1'b1);
  endtask
  initial begin
    tv[0] = '{12'hFF6, 12'hFF6, 12'h6FF};
    tv[1] = '{12'h123, 12'h123, 12'hC48};
    tv[2] = '{12'h000, 12'h000, 12'h000};
    tv[3] = '{12'hFFF, 12'hFFF, 12'hFFF};
    tv[4] = '{12'h800, SAT,     12'h001};
    tv[5] = '{12'h001, 12'h001, SAT};
    tv[6] = '{12'hA5A, 12'hA5A, 12'h5A5};
    #12;
    chk("rst_dout", d_out, 12'h000);
    chk("rst_flags", {d_valid, overrun, frame_err, busy}, 4'b0000);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    d_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      send(tv[k].w, 12);
      chk("tbl_dout", d_out, tv[k].em);
      chk("tbl_dout_lsb", d_out_l, tv[k].el);
      chk("tbl_valid", d_valid, 1'b1);
      step(1'b0, 1'b0);
      chk("tbl_valid_drop", {d_valid, busy}, 2'b00);
    end
    // overrun: second word dropped while first is held
    d_ready = 1'b0;
    send(12'h123, 12);
    step(1'b0, 1'b0);
    send(12'h456, 12);
    chk("ovr_pulse", overrun, 1'b1);
    chk("ovr_hold", d_out, 12'h123);
    step(1'b0, 1'b0);
    chk("ovr_once", {overrun, d_valid}, 2'b01);
    chk("ovr_hold2", d_out, 12'h123);
    d_ready = 1'b1;
    step(1'b0, 1'b0);
    chk("ovr_xfer", d_valid, 1'b0);
    // completion coinciding with a transfer loads without overrun
    d_ready = 1'b0;
    send(12'h321, 12);
    step(1'b0, 1'b0);
    send(12'h654, 11);
    d_ready = 1'b1;
    send(12'h654 << 11, 1);
    chk("same_cyc_dout", d_out, 12'h654);
    chk("same_cyc_flags", {d_valid, overrun}, 2'b10);
    step(1'b0, 1'b0);
    chk("same_cyc_drop", d_valid, 1'b0);
    // short frame
    send(12'hFFF, 7);
    step(1'b0, 1'b0);
    chk("ferr_pulse", {frame_err, d_valid, busy}, 3'b100);
    step(1'b0, 1'b0);
    chk("ferr_once", frame_err, 1'b0);
    send(12'h07F, 12);
    chk("ferr_next", d_out, 12'h07F);
    chk("ferr_next_v", d_valid, 1'b1);
    step(1'b0, 1'b0);
    // long frame: extra bits ignored
    send(12'h3C5, 12);
    chk("long_dout", d_out, 12'h3C5);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("long_busy", {busy, d_valid}, 2'b10);
    chk("long_keep", d_out, 12'h3C5);
    sframe = 1'b0;
    chk("long_busy_fall", busy, 1'b1);
    step(1'b0, 1'b0);
    chk("long_idle", busy, 1'b0);
    // reset mid-frame with a held word
    d_ready = 1'b0;
    send(12'hABC, 12);
    step(1'b0, 1'b0);
    chk("rst_pre", d_out, 12'hABC);
    send(12'hFFF, 5);
    rst_n = 1'b0;
    #1;
    chk("rst_async_dout", d_out, 12'h000);
    chk("rst_async_flags", {d_valid, overrun, frame_err, busy}, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("rst_no_ferr", {frame_err, busy}, 2'b00);
    send(12'h5A3, 12);
    chk("rst_after", d_out, 12'h5A3);
    chk("rst_after_v", d_valid, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
